// File: rtl/regfile_decoded_nport.sv
// DEPTH x WIDTH register file with one write port and NUM_RD registered read ports, all selected through one-hot wordlines.
// Optional macro RF_BYPASS_EN: a read of the register being written on the same edge returns the incoming write data.
module regfile_decoded_nport #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 4,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*WIDTH-1:0]  rd_data,
   output logic [NUM_RD-1:0]        rd_valid,
   output logic                     addr_err
);

   // An address at or above DEPTH decodes to no wordline, so range checks are simply "no bit set".
   function automatic logic [DEPTH-1:0] decode(input logic [ADDR_W-1:0] addr);
      logic [DEPTH-1:0] wl;
      wl = '0;
      for (int i = 0; i < DEPTH; i++) begin
         wl[i] = (addr == ADDR_W'(i));
      end
      return wl;
   endfunction

   logic [WIDTH-1:0]        mem_q [DEPTH];
   logic [NUM_RD*WIDTH-1:0] rd_data_q, rd_data_d;
   logic [NUM_RD-1:0]       rd_valid_q, rd_valid_d;
   logic                    addr_err_q, addr_err_d;

   logic [DEPTH-1:0]        wr_dec;
   logic [DEPTH-1:0]        wr_wl;
   logic [WIDTH-1:0]        rd_src [DEPTH];

   always_comb begin
      wr_dec = decode(wr_addr);
      wr_wl  = wr_en ? wr_dec : '0;
      if (ZERO_REG != 0) begin
         wr_wl[0] = 1'b0;
      end
   end

   // Value each register presents to the read AND-OR tree this cycle.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         rd_src[i] = mem_q[i];
`ifdef RF_BYPASS_EN
         if (wr_wl[i]) begin
            rd_src[i] = wr_data;
         end
`endif
         if ((ZERO_REG != 0) && (i == 0)) begin
            rd_src[i] = '0;
         end
      end
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      logic [DEPTH-1:0] rd_wl;
      logic [WIDTH-1:0] sel;

      rd_data_d  = rd_data_q;
      rd_valid_d = rd_en;
      addr_err_d = addr_err_q | (wr_en & ~(|wr_dec));

      for (int p = 0; p < NUM_RD; p++) begin
         rd_wl = decode(rd_addr[p*ADDR_W +: ADDR_W]);
         sel   = '0;
         for (int i = 0; i < DEPTH; i++) begin
            sel = sel | (rd_src[i] & {WIDTH{rd_wl[i]}});
         end
         if (rd_en[p]) begin
            rd_data_d[p*WIDTH +: WIDTH] = sel;
            addr_err_d = addr_err_d | ~(|rd_wl);
         end
      end
   end

   // NOTE: storage is reset along with the outputs, so every register reads as 0 after rst rather than X.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_data_q  <= '0;
         rd_valid_q <= '0;
         addr_err_q <= 1'b0;
      end else begin
         // NOTE: non-blocking updates keep every same-edge read on the pre-write storage.
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_wl[i]) begin
               mem_q[i] <= wr_data;
            end
         end
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         addr_err_q <= addr_err_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign addr_err = addr_err_q;

endmodule
